// File: rtl/serial_cfg_master.sv
// serial_cfg_master
//   Upstream driver for the gain-programming backend. Latches a 5-bit gain word
//   on a start handshake, holds the backend in reset for RST_CYCLES clocks, then
//   shifts LEAD_BITS dummy zeros followed by {gainA2, gainA1} LSB first on a
//   3-wire link. It finally waits up to TIMEOUT clocks for the backend ready flag.
//
// Ports
//   i_clk        system clock (also clocks the backend)
//   i_resetAll   asynchronous active-high reset, released synchronously inside
//   i_start      frame request, accepted only while o_busy=0
//   i_gainA1     2-bit gain code for amp 1, captured at accept
//   i_gainA2     3-bit gain code for amp 2, captured at accept
//   i_ready      backend ready flag (same clock domain)
//   o_busy       frame in progress
//   o_done       one-cycle pulse at frame end (success or timeout)
//   o_error      sticky: last frame timed out waiting for i_ready
//   o_resetbAll  active-low backend reset
//   o_sclk       serial clock, idles low
//   o_sdin       serial data, idles low
module serial_cfg_master #(
    parameter int CLK_DIV    = 2,
    parameter int RST_CYCLES = 4,
    parameter int LEAD_BITS  = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic       i_clk,
    input  logic       i_resetAll,
    input  logic       i_start,
    input  logic [1:0] i_gainA1,
    input  logic [2:0] i_gainA2,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic       o_resetbAll,
    output logic       o_sclk,
    output logic       o_sdin
);
    localparam int N_BITS = LEAD_BITS + 5;
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int BIT_W  = $clog2(N_BITS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETUP,
        S_SHIFT,
        S_WAIT_RDY
    } state_t;

    state_t           state_reg;
    logic [4:0]       data_reg;
    logic [RST_W-1:0] rst_cnt_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             error_reg;
    logic             resetb_reg;
    logic             sclk_reg;
    logic             sdin_reg;

    // Reset asserts immediately but is released two clocks later, so the FSM
    // always leaves reset cleanly aligned to i_clk.
    logic [1:0] rst_pipe_reg;
    logic       rst_int;

    always_ff @(posedge i_clk or posedge i_resetAll) begin
        if (i_resetAll) begin
            rst_pipe_reg <= 2'b11;
        end else begin
            rst_pipe_reg <= {rst_pipe_reg[0], 1'b0};
        end
    end

    assign rst_int = rst_pipe_reg[1];

    // Whole frame as it appears on the wire, index 0 sent first: leading
    // dummy zeros, then the latched word LSB first.
    logic [N_BITS-1:0] frame_bits;

    generate
        for (genvar gi = 0; gi < N_BITS; gi++) begin : g_frame
            if (gi < LEAD_BITS) begin : g_lead
                assign frame_bits[gi] = 1'b0;
            end else begin : g_data
                assign frame_bits[gi] = data_reg[gi - LEAD_BITS];
            end
        end
    endgenerate

    logic [BIT_W-1:0] bit_next;
    assign bit_next = bit_cnt_reg + BIT_W'(1);

    always_ff @(posedge i_clk or posedge rst_int) begin
        if (rst_int) begin
            state_reg   <= S_IDLE;
            data_reg    <= '0;
            rst_cnt_reg <= '0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            resetb_reg  <= 1'b0;
            sclk_reg    <= 1'b0;
            sdin_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        data_reg    <= {i_gainA2, i_gainA1};
                        error_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        resetb_reg  <= 1'b0;
                        rst_cnt_reg <= '0;
                        state_reg   <= S_RST;
                    end
                end
                S_RST: begin
                    if (rst_cnt_reg == RST_W'(RST_CYCLES - 1)) begin
                        resetb_reg  <= 1'b1;
                        div_cnt_reg <= '0;
                        state_reg   <= S_SETUP;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + RST_W'(1);
                    end
                end
                S_SETUP: begin
                    if (div_cnt_reg == DIV_W'(CLK_DIV - 1)) begin
                        // First period starts low with its bit already on sdin.
                        div_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        sclk_reg    <= 1'b0;
                        sdin_reg    <= frame_bits[0];
                        state_reg   <= S_SHIFT;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (div_cnt_reg != DIV_W'(CLK_DIV - 1)) begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end else begin
                        div_cnt_reg <= '0;
                        if (!sclk_reg) begin
                            // Rising edge: data is held, the backend samples here.
                            sclk_reg <= 1'b1;
                        end else if (bit_cnt_reg == BIT_W'(N_BITS - 1)) begin
                            sclk_reg    <= 1'b0;
                            sdin_reg    <= 1'b0;
                            tmo_cnt_reg <= '0;
                            state_reg   <= S_WAIT_RDY;
                        end else begin
                            // Period boundary: falling edge and next bit together.
                            sclk_reg    <= 1'b0;
                            sdin_reg    <= frame_bits[bit_next];
                            bit_cnt_reg <= bit_next;
                        end
                    end
                end
                S_WAIT_RDY: begin
                    // Ready is checked first so it wins over a coincident timeout.
                    if (i_ready) begin
                        done_reg  <= 1'b1;
                        error_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
                        done_reg  <= 1'b1;
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = busy_reg;
    assign o_done      = done_reg;
    assign o_error     = error_reg;
    assign o_resetbAll = resetb_reg;
    assign o_sclk      = sclk_reg;
    assign o_sdin      = sdin_reg;

endmodule

// File: tb/tb_serial_cfg_master.sv
// Directed testbench for serial_cfg_master with default parameters
// (CLK_DIV=2, RST_CYCLES=4, LEAD_BITS=1, TIMEOUT=64). Cycle index c counts
// clock edges after the accepting edge; outputs are sampled 1 time unit
// after each rising edge.
module tb_serial_cfg_master;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] gain_a1 = 2'b00;
    logic [2:0] gain_a2 = 3'b000;
    logic       ready = 1'b0;
    logic       busy, done, error, resetb, sclk, sdin;

    int checks = 0;
    int failures = 0;

    // Observations from the most recent run_frame call.
    logic obs_bits[$];
    int   obs_rise[$];
    int   obs_rst_low;
    int   obs_shift_end;
    int   obs_done_c;
    int   obs_done_n;
    int   obs_busy_fall;
    int   obs_busy_after;
    int   obs_sdin_bad;
    logic obs_err_at_done;
    logic obs_err_at_accept;
    logic obs_resetb_end;

    serial_cfg_master dut (
        .i_clk       (clk),
        .i_resetAll  (rst),
        .i_start     (start),
        .i_gainA1    (gain_a1),
        .i_gainA2    (gain_a2),
        .i_ready     (ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error),
        .o_resetbAll (resetb),
        .o_sclk      (sclk),
        .o_sdin      (sdin)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] obs_vec();
        logic [5:0] v;
        v = '0;
        for (int i = 0; i < obs_bits.size() && i < 6; i++) v[i] = obs_bits[i];
        return v;
    endfunction

    // Issues one frame request and records what appears on the wire. The
    // backend ready flag rises ready_delay cycles after the last sclk fall
    // (never if negative). A second start pulse with other gains is
    // optionally driven at cycle pulse_at.
    task automatic run_frame(input logic [1:0] a1, input logic [2:0] a2,
                             input int ready_delay, input int pulse_at,
                             input logic [1:0] pa1, input logic [2:0] pa2);
        int   c;
        logic sclk_prev;
        logic sdin_prev;
        obs_bits.delete();
        obs_rise.delete();
        obs_rst_low = 0;
        obs_shift_end = -1;
        obs_done_c = -1;
        obs_done_n = 0;
        obs_busy_fall = -1;
        obs_busy_after = 0;
        obs_sdin_bad = 0;
        obs_err_at_done = 1'bx;
        start = 1'b1;
        gain_a1 = a1;
        gain_a2 = a2;
        tick();
        start = 1'b0;
        c = 0;
        sclk_prev = 1'b0;
        sdin_prev = 1'b0;
        obs_err_at_accept = error;
        while (c < 200) begin
            if (busy && !resetb) obs_rst_low++;
            if (sclk && !sclk_prev) begin
                obs_bits.push_back(sdin);
                obs_rise.push_back(c);
            end
            if (sclk && (sdin !== sdin_prev)) obs_sdin_bad++;
            if (!sclk && sclk_prev && obs_bits.size() == 6 && obs_shift_end < 0) obs_shift_end = c;
            if (done) begin
                obs_done_n++;
                if (obs_done_c < 0) begin
                    obs_done_c = c;
                    obs_err_at_done = error;
                end
            end
            if (!busy && obs_busy_fall < 0) obs_busy_fall = c;
            if (busy && obs_done_c >= 0 && c > obs_done_c) obs_busy_after++;
            sclk_prev = sclk;
            sdin_prev = sdin;
            ready = (ready_delay >= 0 && obs_shift_end >= 0 && obs_done_c < 0 &&
                     c >= obs_shift_end + ready_delay);
            if (c == pulse_at) begin
                start = 1'b1;
                gain_a1 = pa1;
                gain_a2 = pa2;
            end else begin
                start = 1'b0;
                gain_a1 = a1;
                gain_a2 = a2;
            end
            if (obs_done_c >= 0 && c >= obs_done_c + 4) break;
            tick();
            c++;
        end
        start = 1'b0;
        ready = 1'b0;
        obs_resetb_end = resetb;
        $display("frame a1=%b a2=%b bits=%b shift_end=%0d done_c=%0d err=%b",
                 a1, a2, obs_vec(), obs_shift_end, obs_done_c, obs_err_at_done);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, error, resetb, sclk, sdin} !== 6'b0) begin
            failures++;
            $display("FAIL reset_async: got %b expected 000000", {busy, done, error, resetb, sclk, sdin});
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        checks++;
        if (resetb !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_resetb: got %b expected 0", resetb);
        end
        checks++;
        if ({busy, done, sclk, sdin} !== 4'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got %b expected 0000", {busy, done, sclk, sdin});
        end
        $display("reset done");
    endtask

    task automatic test_frame();
        logic [5:0] v;
        run_frame(2'b01, 3'b110, 22, -1, 2'b00, 3'b000);
        v = obs_vec();
        checks++;
        if (obs_rst_low != 4) begin
            failures++;
            $display("FAIL frame_rst_low: got %0d expected 4", obs_rst_low);
        end
        checks++;
        if (obs_bits.size() != 6 || v !== 6'b110010) begin
            failures++;
            $display("FAIL frame_bits: got n=%0d %b expected n=6 110010", obs_bits.size(), v);
        end
        checks++;
        if ({v[2], v[1]} !== 2'b01 || {v[5], v[4], v[3]} !== 3'b110) begin
            failures++;
            $display("FAIL frame_backend_gains: got %b/%b expected 01/110", {v[2], v[1]}, {v[5], v[4], v[3]});
        end
        checks++;
        if (obs_rise.size() != 6 || obs_rise[0] != 8 || obs_rise[5] != 28) begin
            failures++;
            $display("FAIL frame_rise_timing: got n=%0d first=%0d expected n=6 first=8 last=28",
                     obs_rise.size(), (obs_rise.size() > 0) ? obs_rise[0] : -1);
        end
        checks++;
        if (obs_sdin_bad != 0) begin
            failures++;
            $display("FAIL frame_sdin_stable: got %0d changes while sclk high expected 0", obs_sdin_bad);
        end
        checks++;
        if (obs_shift_end != 30) begin
            failures++;
            $display("FAIL frame_shift_end: got %0d expected 30", obs_shift_end);
        end
        checks++;
        if (obs_done_c != 53 || obs_done_n != 1) begin
            failures++;
            $display("FAIL ready_done: got cycle=%0d pulses=%0d expected cycle=53 pulses=1", obs_done_c, obs_done_n);
        end
        checks++;
        if (obs_err_at_done !== 1'b0) begin
            failures++;
            $display("FAIL ready_error: got %b expected 0", obs_err_at_done);
        end
        checks++;
        if (obs_busy_fall != obs_done_c) begin
            failures++;
            $display("FAIL ready_busy_fall: got %0d expected %0d", obs_busy_fall, obs_done_c);
        end
        checks++;
        if (obs_resetb_end !== 1'b1) begin
            failures++;
            $display("FAIL frame_resetb_after: got %b expected 1", obs_resetb_end);
        end
    endtask

    task automatic test_timeout();
        run_frame(2'b11, 3'b000, -1, -1, 2'b00, 3'b000);
        checks++;
        if (obs_done_c != 94 || obs_done_n != 1) begin
            failures++;
            $display("FAIL timeout_done: got cycle=%0d pulses=%0d expected cycle=94 pulses=1", obs_done_c, obs_done_n);
        end
        checks++;
        if (obs_err_at_done !== 1'b1) begin
            failures++;
            $display("FAIL timeout_error: got %b expected 1", obs_err_at_done);
        end
        repeat (5) tick();
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got %b expected 1", error);
        end
    endtask

    task automatic test_ignore_start();
        run_frame(2'b10, 3'b011, 3, 15, 2'b01, 3'b110);
        checks++;
        if (obs_err_at_accept !== 1'b0) begin
            failures++;
            $display("FAIL ignore_error_cleared: got %b expected 0", obs_err_at_accept);
        end
        checks++;
        if (obs_bits.size() != 6 || obs_vec() !== 6'b011100) begin
            failures++;
            $display("FAIL ignore_bits: got n=%0d %b expected n=6 011100", obs_bits.size(), obs_vec());
        end
        checks++;
        if (obs_done_c != 34 || obs_done_n != 1) begin
            failures++;
            $display("FAIL ignore_done: got cycle=%0d pulses=%0d expected cycle=34 pulses=1", obs_done_c, obs_done_n);
        end
        checks++;
        if (obs_busy_after != 0) begin
            failures++;
            $display("FAIL ignore_no_requeue: got %0d busy cycles after done expected 0", obs_busy_after);
        end
    endtask

    task automatic test_reset_mid_shift();
        start = 1'b1;
        gain_a1 = 2'b10;
        gain_a2 = 3'b111;
        tick();
        start = 1'b0;
        repeat (20) tick();
        checks++;
        if (sclk !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: got sclk=%b busy=%b expected 1 1", sclk, busy);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({sclk, sdin, resetb, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_async: got %b expected 00000", {sclk, sdin, resetb, busy, done});
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        checks++;
        if ({done, busy, resetb} !== 3'b0) begin
            failures++;
            $display("FAIL midreset_after: got %b expected 000", {done, busy, resetb});
        end
        $display("mid-shift reset applied");
        run_frame(2'b11, 3'b101, 0, -1, 2'b00, 3'b000);
        checks++;
        if (obs_bits.size() != 6 || obs_vec() !== 6'b101110) begin
            failures++;
            $display("FAIL midreset_frame_bits: got n=%0d %b expected n=6 101110", obs_bits.size(), obs_vec());
        end
        checks++;
        if (obs_rst_low != 4 || obs_done_c != 31 || obs_err_at_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_frame_end: got rst_low=%0d done=%0d err=%b expected 4 31 0",
                     obs_rst_low, obs_done_c, obs_err_at_done);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_timeout();
        test_ignore_start();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
